// File: rtl/irq_fifo_reader.sv
// Config-bus reader that drains the NI interrupt FIFO into a valid/ready event stream.
// Optional round-robin queue arbitration when IRQ_FIFO_READER_RR_EN is defined.
//
// state | meaning
// IDLE  | waiting for a non-empty queue; arbitrate and latch kind
// REQ   | one-cycle config read strobe at BASE_ADDR | kind
// RESP  | capture read data and error flag
// OUT   | present event until consumer handshake
module irq_fifo_reader #(
  parameter logic [13:0] BASE_ADDR = 14'h0000,
  parameter int          ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 irq_irq_sig,
  input  logic                 irq_data_sig,
  output logic                 sel,
  output logic                 config_en,
  output logic                 config_wr,
  output logic [13:0]          config_addr,
  output logic [31:0]          config_wdata,
  input  logic [31:0]          config_slv_rdata,
  input  logic                 config_slv_error,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic                 evt_kind,
  output logic [13:0]          evt_data,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0] state;
  logic       kind;
  logic       pick_irq;
  logic       unused_rdata_hi;

  assign config_wr       = 1'b0;
  assign config_wdata    = 32'h0;
  assign unused_rdata_hi = ^config_slv_rdata[31:14];

`ifdef IRQ_FIFO_READER_RR_EN
  logic last_irq;
  // On a tie, serve the queue that was not served last.
  always_comb pick_irq = irq_irq_sig && (!irq_data_sig || !last_irq);
`else
  always_comb pick_irq = irq_irq_sig;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      kind        <= 1'b0;
      sel         <= 1'b0;
      config_en   <= 1'b0;
      config_addr <= 14'h0;
      evt_valid   <= 1'b0;
      evt_kind    <= 1'b0;
      evt_data    <= 14'h0;
      err_cnt     <= '0;
`ifdef IRQ_FIFO_READER_RR_EN
      last_irq    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (irq_irq_sig || irq_data_sig) begin
            kind        <= pick_irq;
            sel         <= 1'b1;
            config_en   <= 1'b1;
            config_addr <= BASE_ADDR | {13'b0, pick_irq};
            state       <= REQ;
`ifdef IRQ_FIFO_READER_RR_EN
            last_irq    <= pick_irq;
`endif
          end
        end
        REQ: begin
          sel         <= 1'b0;
          config_en   <= 1'b0;
          config_addr <= 14'h0;
          state       <= RESP;
        end
        RESP: begin
          if (config_slv_error) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            state <= IDLE;
          end else begin
            evt_data  <= config_slv_rdata[13:0];
            evt_kind  <= kind;
            evt_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_fifo_reader.sv
// Self-checking bench for irq_fifo_reader: FIFO responder, timeline reference model,
// directed scenarios and a randomized phase. Honors IRQ_FIFO_READER_RR_EN.
module tb_irq_fifo_reader;

  localparam logic [13:0] BASE = 14'h0800;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        irq_irq_sig = 1'b0;
  logic        irq_data_sig = 1'b0;
  logic        sel, config_en, config_wr;
  logic [13:0] config_addr;
  logic [31:0] config_wdata;
  logic [31:0] config_slv_rdata = 32'h0;
  logic        config_slv_error = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic        evt_kind;
  logic [13:0] evt_data;
  logic [7:0]  err_cnt;

  irq_fifo_reader #(.BASE_ADDR(BASE), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .irq_irq_sig(irq_irq_sig), .irq_data_sig(irq_data_sig),
    .sel(sel), .config_en(config_en), .config_wr(config_wr),
    .config_addr(config_addr), .config_wdata(config_wdata),
    .config_slv_rdata(config_slv_rdata), .config_slv_error(config_slv_error),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_kind(evt_kind),
    .evt_data(evt_data), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO contents: bit 14 marks an entry whose read returns an error.
  logic [14:0] q_irq[$];
  logic [14:0] q_data[$];

  // Observation logs for directed checks.
  int          en_log[$];
  int          hs_log[$];
  logic        log_kind[$];
  logic [13:0] log_data[$];

  // Reference model: timeline of the current visit.
  bit          m_pend = 0;
  int          m_free_from = 0;
  int          m_req_cyc = -1;
  int          m_valid_from = 0;
  int          m_resp_err_cyc = -1;
  bit          m_kind = 0;
  bit          m_last = 0;
  logic [13:0] m_data = 0;
  int          m_err = 0;

  bit          resp_pending = 0;
  logic [14:0] resp_entry = 0;

  function automatic bit model_idle();
    return !m_pend && cyc >= m_free_from && q_irq.size() == 0 && q_data.size() == 0;
  endfunction

  always @(negedge clk) begin
    int          n;
    bit          exp_en, exp_valid, slot;
    logic [14:0] ent;
    logic [31:0] r;
    #1;
    n = cyc;
    exp_en    = (n == m_req_cyc);
    exp_valid = m_pend && n >= m_valid_from;
    chk("config_en", config_en, exp_en);
    chk("sel", sel, exp_en);
    chk("config_wr", config_wr, 0);
    chk("config_wdata", config_wdata, 0);
    if (exp_en) chk("config_addr", config_addr, BASE | {13'b0, m_kind});
    chk("evt_valid", evt_valid, exp_valid);
    if (exp_valid) begin
      chk("evt_kind", evt_kind, m_kind);
      chk("evt_data", evt_data, m_data);
    end
    chk("err_cnt", err_cnt, m_err);

    if (config_en) en_log.push_back(n);
    if (evt_valid && evt_ready) begin
      hs_log.push_back(n);
      log_kind.push_back(evt_kind);
      log_data.push_back(evt_data);
    end

    // FIFO responder: data/error are valid only in the cycle after the access.
    r = $urandom;
    if (resp_pending && !reset) begin
      r[13:0] = resp_entry[13:0];
      config_slv_error = resp_entry[14];
    end else begin
      config_slv_error = 1'($urandom);
    end
    config_slv_rdata = r;
    resp_pending = 0;
    if (config_en && !reset) begin
      ent = 15'($urandom);
      if (config_addr[0] && q_irq.size() > 0) ent = q_irq.pop_front();
      else if (!config_addr[0] && q_data.size() > 0) ent = q_data.pop_front();
      resp_entry   = ent;
      resp_pending = 1;
    end
    irq_irq_sig  = (q_irq.size() != 0);
    irq_data_sig = (q_data.size() != 0);

    // Advance the model over the upcoming clock edge.
    if (reset) begin
      m_pend = 0; m_free_from = n + 1; m_req_cyc = -1; m_resp_err_cyc = -1;
      m_err = 0; m_last = 0;
    end else begin
      if (n == m_resp_err_cyc && m_err < 255) m_err++;
      if (m_pend && n >= m_valid_from && evt_ready) begin
        m_pend = 0;
        m_free_from = n + 1;
      end else if (!m_pend && n >= m_free_from && (irq_irq_sig || irq_data_sig)) begin
`ifdef IRQ_FIFO_READER_RR_EN
        slot = (irq_irq_sig && irq_data_sig) ? !m_last : irq_irq_sig;
`else
        slot = irq_irq_sig;
`endif
        ent = slot ? q_irq[0] : q_data[0];
        m_kind = slot;
        m_last = slot;
        m_req_cyc = n + 1;
        if (ent[14]) begin
          m_resp_err_cyc = n + 2;
          m_free_from = n + 3;
        end else begin
          m_pend = 1;
          m_valid_from = n + 3;
          m_data = ent[13:0];
        end
      end
    end
  end

  task automatic clear_logs();
    en_log.delete(); hs_log.delete(); log_kind.delete(); log_data.delete();
  endtask

  task automatic wait_idle(int max_cyc);
    int k = 0;
    bit done = 0;
    while (!done && k < max_cyc) begin
      @(negedge clk); #2; k++;
      done = model_idle();
    end
    chk("wait_idle_done", done, 1);
    repeat (4) @(negedge clk);
    #2;
  endtask

  task automatic wait_valid(int max_cyc);
    int k = 0;
    do begin @(negedge clk); #2; k++; end while (!evt_valid && k < max_cyc);
    chk("wait_valid_done", evt_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic        ord_kind[4];
    logic [13:0] ord_data[4];

    repeat (3) @(negedge clk);
    #2;
    chk("rst_sel", sel, 0);
    chk("rst_config_en", config_en, 0);
    chk("rst_config_addr", config_addr, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_kind", evt_kind, 0);
    chk("rst_evt_data", evt_data, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    reset = 0;

    // Single IRQ entry.
    @(negedge clk);
    clear_logs();
    evt_ready = 1;
    q_irq.push_back({1'b0, 14'h0A5});
    wait_idle(50);
    chk("t1_reads", en_log.size(), 1);
    chk("t1_events", log_kind.size(), 1);
    if (log_kind.size() == 1) begin
      chk("t1_kind", log_kind[0], 1);
      chk("t1_data", log_data[0], 14'h0A5);
    end

    // Data queue drain.
    @(negedge clk);
    clear_logs();
    q_data.push_back({1'b0, 14'h001});
    q_data.push_back({1'b0, 14'h002});
    q_data.push_back({1'b0, 14'h003});
    wait_idle(60);
    chk("t2_reads", en_log.size(), 3);
    chk("t2_events", log_data.size(), 3);
    if (en_log.size() == 3 && log_data.size() == 3) begin
      chk("t2_gap0", en_log[1] - en_log[0], 4);
      chk("t2_gap1", en_log[2] - en_log[1], 4);
      for (int i = 0; i < 3; i++) begin
        chk("t2_kind", log_kind[i], 0);
        chk("t2_data", log_data[i], 14'(i + 1));
      end
    end

    // Both queues with two entries each.
`ifdef IRQ_FIFO_READER_RR_EN
    ord_kind = '{1'b1, 1'b0, 1'b1, 1'b0};
    ord_data = '{14'h010, 14'h020, 14'h011, 14'h021};
`else
    ord_kind = '{1'b1, 1'b1, 1'b0, 1'b0};
    ord_data = '{14'h010, 14'h011, 14'h020, 14'h021};
`endif
    @(negedge clk);
    clear_logs();
    q_irq.push_back({1'b0, 14'h010});
    q_irq.push_back({1'b0, 14'h011});
    q_data.push_back({1'b0, 14'h020});
    q_data.push_back({1'b0, 14'h021});
    wait_idle(80);
    chk("t3_events", log_kind.size(), 4);
    if (log_kind.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t3_kind", log_kind[i], ord_kind[i]);
        chk("t3_data", log_data[i], ord_data[i]);
      end
    end

    // Backpressure.
    @(negedge clk);
    clear_logs();
    evt_ready = 0;
    q_data.push_back({1'b0, 14'h155});
    q_data.push_back({1'b0, 14'h2AA});
    wait_valid(20);
    repeat (10) begin
      @(negedge clk); #2;
      chk("t4_valid", evt_valid, 1);
      chk("t4_data", evt_data, 14'h155);
      chk("t4_no_en", config_en, 0);
    end
    @(negedge clk);
    evt_ready = 1;
    wait_idle(50);
    chk("t4_reads", en_log.size(), 2);
    chk("t4_events", hs_log.size(), 2);
    if (en_log.size() == 2 && hs_log.size() == 2) begin
      chk("t4_restart", en_log[1] - hs_log[0], 2);
      chk("t4_data2", log_data[1], 14'h2AA);
    end

    // Error response and saturation.
    @(negedge clk);
    clear_logs();
    q_data.push_back({1'b1, 14'h3FF});
    wait_idle(50);
    chk("t5_no_event", log_kind.size(), 0);
    chk("t5_err_one", err_cnt, 1);
    @(negedge clk);
    for (int i = 0; i < 300; i++) q_data.push_back({1'b1, 14'(i)});
    wait_idle(2000);
    chk("t5_err_sat", err_cnt, 255);
    chk("t5_no_event2", log_kind.size(), 0);

    // Reset while holding an event.
    @(negedge clk);
    evt_ready = 0;
    q_irq.push_back({1'b0, 14'h077});
    wait_valid(20);
    @(negedge clk);
    reset = 1;
    q_irq.delete();
    q_data.delete();
    clear_logs();
    @(negedge clk);
    reset = 0;
    #2;
    chk("t6_sel", sel, 0);
    chk("t6_config_en", config_en, 0);
    chk("t6_config_addr", config_addr, 0);
    chk("t6_evt_valid", evt_valid, 0);
    chk("t6_evt_kind", evt_kind, 0);
    chk("t6_evt_data", evt_data, 0);
    chk("t6_err_cnt", err_cnt, 0);
    repeat (10) @(negedge clk);
    #2;
    chk("t6_no_reads", en_log.size(), 0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      evt_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 5) == 0)
        q_irq.push_back({($urandom_range(0, 7) == 0), 14'($urandom)});
      if ($urandom_range(0, 5) == 0)
        q_data.push_back({($urandom_range(0, 7) == 0), 14'($urandom)});
    end
    @(negedge clk);
    evt_ready = 1;
    wait_idle(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
